// File: rtl/cnu_msg_gather.sv
// cnu_msg_gather
// Upstream feeder for the min-sum check node unit. Each accepted message is
// llr - rold (layered update), saturated symmetrically to +/-(2**(data_w-1)-1)
// and written into a ping-pong buffer of two D-slot banks. A completed bank is
// presented on q with q_valid, which drives the check node enable.
// rst is synchronous and active-low.

module cnu_msg_gather #(
    parameter int D     = 8,
    parameter int res_w = 8,
    parameter int ext_w = 3,
    parameter int idx_w = 3
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic                      in_last,
    input  logic [res_w+ext_w-1:0]    llr,
    input  logic [res_w-1:0]          rold,
    output logic [(res_w+ext_w)*D-1:0] q,
    output logic                      q_valid,
    input  logic                      q_ready,
    output logic [idx_w-1:0]          cnt,
    output logic                      err
);

    localparam int data_w = res_w + ext_w;
    localparam logic [idx_w-1:0] last_idx = idx_w'(D - 1);

    // Symmetric saturation bounds in the data_w+1 bit difference domain.
    // The most negative code -2**(data_w-1) is deliberately excluded so the
    // check node can negate any stored value without overflow.
    localparam logic signed [data_w:0] sat_pos = {2'b00, {(data_w-1){1'b1}}};
    localparam logic signed [data_w:0] sat_neg = {2'b11, {(data_w-2){1'b0}}, 1'b1};

    // Difference of posterior LLR and sign-extended old check message,
    // clamped to the symmetric range and returned in data_w bits.
    function automatic logic [data_w-1:0] sat_msg(
        input logic [data_w-1:0] llr_v,
        input logic [res_w-1:0]  rold_v
    );
        logic signed [data_w:0] diff;
        diff = $signed({llr_v[data_w-1], llr_v})
             - $signed({{(ext_w+1){rold_v[res_w-1]}}, rold_v});
        if (diff > sat_pos) begin
            return sat_pos[data_w-1:0];
        end else if (diff < sat_neg) begin
            return sat_neg[data_w-1:0];
        end else begin
            return diff[data_w-1:0];
        end
    endfunction

    logic [1:0][D*data_w-1:0] bank_r;
    logic [1:0][D*data_w-1:0] bank_nxt_s;
    logic [1:0]               full_r;
    logic [1:0]               full_nxt_s;
    logic                     wr_bank_r;
    logic                     wr_bank_nxt_s;
    logic                     rd_bank_r;
    logic                     rd_bank_nxt_s;
    logic [idx_w-1:0]         cnt_r;
    logic [idx_w-1:0]         cnt_nxt_s;
    logic                     err_r;
    logic                     err_nxt_s;
    logic [D*data_w-1:0]      q_r;
    logic                     q_valid_r;
    logic                     in_ready_s;
    logic                     xfer_s;
    logic                     pop_s;
    logic                     at_last_s;

    assign in_ready_s = rst & ~full_r[wr_bank_r];
    assign xfer_s     = in_valid & in_ready_s;
    assign pop_s      = full_r[rd_bank_r] & q_ready;
    assign at_last_s  = (cnt_r == last_idx);

    // Next-state computation for banks, flags, pointers, slot counter and error.
    always_comb begin
        bank_nxt_s    = bank_r;
        full_nxt_s    = full_r;
        wr_bank_nxt_s = wr_bank_r;
        rd_bank_nxt_s = rd_bank_r;
        cnt_nxt_s     = cnt_r;
        err_nxt_s     = err_r;
        if (xfer_s) begin
            bank_nxt_s[wr_bank_r][int'(cnt_r)*data_w +: data_w] = sat_msg(llr, rold);
            if (at_last_s) begin
                cnt_nxt_s             = {idx_w{1'b0}};
                full_nxt_s[wr_bank_r] = 1'b1;
                wr_bank_nxt_s         = ~wr_bank_r;
            end else begin
                cnt_nxt_s = cnt_r + idx_w'(1);
            end
            // in_last only flags misalignment; completion is driven by cnt alone
            if (in_last != at_last_s) begin
                err_nxt_s = 1'b1;
            end else begin
                err_nxt_s = err_r;
            end
        end else begin
            cnt_nxt_s = cnt_r;
        end
        // A pop never collides with a write: the write bank is only the read
        // bank when that bank is empty, and then there is nothing to pop.
        if (pop_s) begin
            full_nxt_s[rd_bank_r] = 1'b0;
            rd_bank_nxt_s         = ~rd_bank_r;
        end else begin
            rd_bank_nxt_s = rd_bank_r;
        end
    end

    // State registers; q and q_valid are loaded from next-state values so a
    // vector completed at an edge is visible right after that edge.
    always_ff @(posedge clk) begin
        if (!rst) begin
            bank_r    <= '0;
            full_r    <= 2'b00;
            wr_bank_r <= 1'b0;
            rd_bank_r <= 1'b0;
            cnt_r     <= {idx_w{1'b0}};
            err_r     <= 1'b0;
            q_r       <= '0;
            q_valid_r <= 1'b0;
        end else begin
            bank_r    <= bank_nxt_s;
            full_r    <= full_nxt_s;
            wr_bank_r <= wr_bank_nxt_s;
            rd_bank_r <= rd_bank_nxt_s;
            cnt_r     <= cnt_nxt_s;
            err_r     <= err_nxt_s;
            q_r       <= bank_nxt_s[rd_bank_nxt_s];
            q_valid_r <= full_nxt_s[rd_bank_nxt_s];
        end
    end

    assign in_ready = in_ready_s;
    assign q        = q_r;
    assign q_valid  = q_valid_r;
    assign cnt      = cnt_r;
    assign err      = err_r;

endmodule

// File: tb/tb_cnu_msg_gather.sv
// Self-checking bench for cnu_msg_gather (D=8, data_w=11).
// Expected vectors are built from the messages as they are driven and queued;
// they are popped and compared when the DUT presents and releases a vector.

module tb_cnu_msg_gather;

    localparam int D  = 8;
    localparam int DW = 11;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic            in_last = 1'b0;
    logic [DW-1:0]   llr = '0;
    logic [7:0]      rold = '0;
    logic [DW*D-1:0] q;
    logic            q_valid;
    logic            q_ready = 1'b0;
    logic [2:0]      cnt;
    logic            err;

    int n_checks = 0;
    int n_pass   = 0;

    logic [DW*D-1:0] exp_q[$];
    logic [DW*D-1:0] cur_vec;
    logic [DW*D-1:0] exp_v;
    int              cur_cnt;
    bit              exp_err;

    cnu_msg_gather dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_last(in_last), .llr(llr), .rold(rold), .q(q), .q_valid(q_valid),
        .q_ready(q_ready), .cnt(cnt), .err(err)
    );

    always #5 clk = ~clk;

    // Reference model of the layered-update message with symmetric saturation.
    function automatic logic [DW-1:0] ref_msg(input int l, input int r);
        int d;
        d = l - r;
        if (d > 1023) d = 1023;
        if (d < -1023) d = -1023;
        return d[DW-1:0];
    endfunction

    task automatic model_clear();
        exp_q.delete();
        cur_vec = '0;
        cur_cnt = 0;
        exp_err = 1'b0;
    endtask

    // One message held for one edge; the model records the expected slot value.
    task automatic send(input int l, input int r, input bit last);
        logic [31:0] lv;
        logic [31:0] rv;
        lv = l;
        rv = r;
        llr      = lv[DW-1:0];
        rold     = rv[7:0];
        in_last  = last;
        in_valid = 1'b1;
        cur_vec[cur_cnt*DW +: DW] = ref_msg(l, r);
        if (last != (cur_cnt == D-1)) exp_err = 1'b1;
        cur_cnt = cur_cnt + 1;
        if (cur_cnt == D) begin
            exp_q.push_back(cur_vec);
            cur_cnt = 0;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic apply_reset();
        rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        model_clear();
    endtask

    task automatic test_reset();
        rst = 1'b0;
        q_ready = 1'b0;
        @(posedge clk); #1;
        model_clear();
        n_checks++; if (q_valid !== 1'b0) $display("FAIL reset_q_valid got=%b exp=0", q_valid); else n_pass++;
        n_checks++; if (q !== '0) $display("FAIL reset_q got=%h exp=0", q); else n_pass++;
        n_checks++; if (cnt !== 3'd0) $display("FAIL reset_cnt got=%0d exp=0", cnt); else n_pass++;
        n_checks++; if (err !== 1'b0) $display("FAIL reset_err got=%b exp=0", err); else n_pass++;
        n_checks++; if (in_ready !== 1'b0) $display("FAIL reset_in_ready got=%b exp=0", in_ready); else n_pass++;
        rst = 1'b1;
        #1;
        n_checks++; if (in_ready !== 1'b1) $display("FAIL post_reset_in_ready got=%b exp=1", in_ready); else n_pass++;
    endtask

    task automatic test_basic();
        bit ready_ok;
        ready_ok = 1'b1;
        q_ready = 1'b1;
        for (int i = 0; i < D; i++) begin
            if (in_ready !== 1'b1) ready_ok = 1'b0;
            send(i*10, -5, i == D-1);
        end
        n_checks++; if (ready_ok !== 1'b1) $display("FAIL basic_in_ready got=dropped exp=always 1"); else n_pass++;
        n_checks++; if (q_valid !== 1'b1) $display("FAIL basic_q_valid got=%b exp=1", q_valid); else n_pass++;
        exp_v = (exp_q.size() > 0) ? exp_q[0] : 'x;
        n_checks++; if (q !== exp_v) $display("FAIL basic_q got=%h exp=%h", q, exp_v); else n_pass++;
        n_checks++; if (q[7*DW +: DW] !== 11'd75) $display("FAIL basic_slot7 got=%0d exp=75", q[7*DW +: DW]); else n_pass++;
        @(posedge clk); #1;
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        q_ready = 1'b0;
        n_checks++; if (q_valid !== 1'b0) $display("FAIL basic_after_pop got=%b exp=0", q_valid); else n_pass++;
        n_checks++; if (cnt !== 3'd0) $display("FAIL basic_cnt got=%0d exp=0", cnt); else n_pass++;
    endtask

    task automatic test_saturation();
        q_ready = 1'b0;
        send(1000, -100, 1'b0);
        send(-1023, 127, 1'b0);
        send(-1024, 0, 1'b0);
        send(1023, -128, 1'b0);
        send(-1024, 127, 1'b0);
        send(5, 5, 1'b0);
        send(-1, 1, 1'b0);
        send(300, -20, 1'b1);
        n_checks++; if (q_valid !== 1'b1) $display("FAIL sat_q_valid got=%b exp=1", q_valid); else n_pass++;
        n_checks++; if (q[0 +: DW] !== 11'h3FF) $display("FAIL sat_pos got=%h exp=3ff", q[0 +: DW]); else n_pass++;
        n_checks++; if (q[DW +: DW] !== 11'h401) $display("FAIL sat_neg1 got=%h exp=401", q[DW +: DW]); else n_pass++;
        n_checks++; if (q[2*DW +: DW] !== 11'h401) $display("FAIL sat_neg2 got=%h exp=401", q[2*DW +: DW]); else n_pass++;
        exp_v = (exp_q.size() > 0) ? exp_q[0] : 'x;
        n_checks++; if (q !== exp_v) $display("FAIL sat_q got=%h exp=%h", q, exp_v); else n_pass++;
        q_ready = 1'b1;
        @(posedge clk); #1;
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        q_ready = 1'b0;
        n_checks++; if (q_valid !== 1'b0) $display("FAIL sat_after_pop got=%b exp=0", q_valid); else n_pass++;
    endtask

    task automatic test_back_to_back();
        q_ready = 1'b0;
        for (int i = 0; i < 2*D; i++) begin
            send($signed(11'($urandom_range(0, 2047))), $signed(8'($urandom_range(0, 255))),
                 (i % D) == D-1);
        end
        n_checks++; if (in_ready !== 1'b0) $display("FAIL b2b_full_in_ready got=%b exp=0", in_ready); else n_pass++;
        n_checks++; if (q_valid !== 1'b1) $display("FAIL b2b_q_valid got=%b exp=1", q_valid); else n_pass++;
        exp_v = (exp_q.size() > 0) ? exp_q[0] : 'x;
        n_checks++; if (q !== exp_v) $display("FAIL b2b_vec1 got=%h exp=%h", q, exp_v); else n_pass++;
        q_ready = 1'b1;
        @(posedge clk); #1;
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        q_ready = 1'b0;
        n_checks++; if (q_valid !== 1'b1) $display("FAIL b2b_q_valid2 got=%b exp=1", q_valid); else n_pass++;
        exp_v = (exp_q.size() > 0) ? exp_q[0] : 'x;
        n_checks++; if (q !== exp_v) $display("FAIL b2b_vec2 got=%h exp=%h", q, exp_v); else n_pass++;
        n_checks++; if (in_ready !== 1'b1) $display("FAIL b2b_in_ready got=%b exp=1", in_ready); else n_pass++;
        // refill the bank just popped, then drain both vectors
        for (int i = 0; i < D; i++) send(i*3 - 7, 2*i, i == D-1);
        q_ready = 1'b1;
        for (int k = 0; k < 2; k++) begin
            exp_v = (exp_q.size() > 0) ? exp_q[0] : 'x;
            n_checks++; if (q !== exp_v || q_valid !== 1'b1) $display("FAIL b2b_drain%0d got=%h/%b exp=%h/1", k, q, q_valid, exp_v); else n_pass++;
            @(posedge clk); #1;
            if (exp_q.size() > 0) void'(exp_q.pop_front());
        end
        q_ready = 1'b0;
        n_checks++; if (q_valid !== 1'b0) $display("FAIL b2b_empty got=%b exp=0", q_valid); else n_pass++;
    endtask

    task automatic test_err();
        q_ready = 1'b0;
        for (int i = 0; i < D; i++) begin
            send(i + 100, i, i == 4);
            if (i == 2) begin
                n_checks++; if (cnt !== 3'd3) $display("FAIL err_cnt got=%0d exp=3", cnt); else n_pass++;
            end
            if (i == 3) begin
                n_checks++; if (err !== 1'b0) $display("FAIL err_early got=%b exp=0", err); else n_pass++;
            end
            if (i == 4) begin
                n_checks++; if (err !== exp_err) $display("FAIL err_set got=%b exp=%b", err, exp_err); else n_pass++;
            end
        end
        n_checks++; if (q_valid !== 1'b1) $display("FAIL err_vec_done got=%b exp=1", q_valid); else n_pass++;
        exp_v = (exp_q.size() > 0) ? exp_q[0] : 'x;
        n_checks++; if (q !== exp_v) $display("FAIL err_vec got=%h exp=%h", q, exp_v); else n_pass++;
        q_ready = 1'b1;
        @(posedge clk); #1;
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        q_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++; if (err !== 1'b1) $display("FAIL err_sticky got=%b exp=1", err); else n_pass++;
        apply_reset();
        n_checks++; if (err !== 1'b0) $display("FAIL err_reset got=%b exp=0", err); else n_pass++;
    endtask

    task automatic test_reset_midvector();
        q_ready = 1'b0;
        for (int i = 0; i < 3; i++) send(50 + i, 1, 1'b0);
        rst = 1'b0;
        #1;
        n_checks++; if (in_ready !== 1'b0) $display("FAIL mid_rst_in_ready got=%b exp=0", in_ready); else n_pass++;
        @(posedge clk); #1;
        model_clear();
        n_checks++; if (cnt !== 3'd0) $display("FAIL mid_rst_cnt got=%0d exp=0", cnt); else n_pass++;
        n_checks++; if (q_valid !== 1'b0) $display("FAIL mid_rst_q_valid got=%b exp=0", q_valid); else n_pass++;
        rst = 1'b1;
        #1;
        for (int i = 0; i < D; i++) send(-200 + 17*i, 3 - i, i == D-1);
        exp_v = (exp_q.size() > 0) ? exp_q[0] : 'x;
        n_checks++; if (q !== exp_v || q_valid !== 1'b1) $display("FAIL mid_clean_vec got=%h/%b exp=%h/1", q, q_valid, exp_v); else n_pass++;
        q_ready = 1'b1;
        @(posedge clk); #1;
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        q_ready = 1'b0;
    endtask

    task automatic test_simultaneous();
        q_ready = 1'b0;
        for (int i = 0; i < D; i++) send(10*i - 40, -i, i == D-1);
        for (int i = 0; i < D-1; i++) send(-7*i, 20, 1'b0);
        n_checks++; if (q_valid !== 1'b1) $display("FAIL simul_pre got=%b exp=1", q_valid); else n_pass++;
        q_ready = 1'b1;
        send(600, -64, 1'b1);
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        q_ready = 1'b0;
        n_checks++; if (q_valid !== 1'b1) $display("FAIL simul_q_valid got=%b exp=1", q_valid); else n_pass++;
        exp_v = (exp_q.size() > 0) ? exp_q[0] : 'x;
        n_checks++; if (q !== exp_v) $display("FAIL simul_bank1 got=%h exp=%h", q, exp_v); else n_pass++;
        q_ready = 1'b1;
        @(posedge clk); #1;
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        q_ready = 1'b0;
        n_checks++; if (q_valid !== 1'b0) $display("FAIL simul_drained got=%b exp=0", q_valid); else n_pass++;
    endtask

    initial begin
        model_clear();
        test_reset();
        test_basic();
        test_saturation();
        test_back_to_back();
        test_err();
        test_reset_midvector();
        test_simultaneous();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
